// File: rtl/hazard_exc_ctrl.sv
// Pipeline sequencing controller: D-stall / E-bubble generation, mult/div busy
// countdown, and exception/interrupt/eret flush with the EXL state bit.
module hazard_exc_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_hazard,
  input  logic             d_uses_md,
  input  logic             e_md_start,
  input  logic             e_md_div,
  input  logic             exc_req,
  input  logic             int_req,
  input  logic             int_en,
  input  logic             eret_m,
  output logic             stall_d,
  output logic             clr_e,
  output logic             flush,
  output logic [1:0]       pc_sel,
  output logic             exl,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
);

  logic             r_exl;
  logic [CNT_W-1:0] r_md_cnt;

  logic w_take;
  logic w_ret;
  logic w_flush;
  logic w_start;
  logic w_cnt_zero;
  logic w_md_busy;
  logic w_stall;

  always_comb begin
    w_take     = (exc_req | (int_req & int_en)) & ~r_exl;
    w_ret      = eret_m & ~w_take;
    w_flush    = w_take | w_ret;
    // A start in a flush cycle belongs to a squashed (younger) E instruction.
    w_start    = e_md_start & ~w_flush;
    w_cnt_zero = (r_md_cnt == '0);
    w_md_busy  = ~w_cnt_zero | w_start;
    // Pipe registers give stall priority over clear, so flush must mask stall.
    w_stall    = (data_hazard | (d_uses_md & w_md_busy)) & ~w_flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exl    <= 1'b0;
      r_md_cnt <= '0;
    end else begin
      if (w_take)
        r_exl <= 1'b1;
      else if (w_ret)
        r_exl <= 1'b0;

      if (w_start && w_cnt_zero)
        r_md_cnt <= e_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (!w_cnt_zero)
        r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    stall_d = w_stall;
    clr_e   = w_stall;
    flush   = w_flush;
    pc_sel  = w_take ? 2'b01 : (w_ret ? 2'b10 : 2'b00);
    exl     = r_exl;
    md_busy = w_md_busy;
    md_cnt  = r_md_cnt;
  end

endmodule

// File: tb/tb_hazard_exc_ctrl.sv
// Bench for hazard_exc_ctrl: directed scenarios plus random traffic, checked
// against a cycle-indexed reference model through an expected-value queue.
module tb_hazard_exc_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CNT_W    = 4;
  localparam int EW       = 7 + CNT_W;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, data_hazard, d_uses_md, e_md_start, e_md_div;
  logic             exc_req, int_req, int_en, eret_m;
  logic             stall_d, clr_e, flush, exl, md_busy;
  logic [1:0]       pc_sel;
  logic [CNT_W-1:0] md_cnt;

  hazard_exc_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .data_hazard(data_hazard), .d_uses_md(d_uses_md),
    .e_md_start(e_md_start), .e_md_div(e_md_div), .exc_req(exc_req),
    .int_req(int_req), .int_en(int_en), .eret_m(eret_m), .stall_d(stall_d),
    .clr_e(clr_e), .flush(flush), .pc_sel(pc_sel), .exl(exl),
    .md_busy(md_busy), .md_cnt(md_cnt)
  );

  // scoreboard: {stall_d, clr_e, flush, pc_sel, exl, md_busy, md_cnt}
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model: the mult/div unit is busy until an absolute cycle number
  int m_cycle   = 0;
  int m_busy_to = 0;
  bit m_exl     = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, m_cycle);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      e = exp_q.pop_front();
      a = {stall_d, clr_e, flush, pc_sel, exl, md_busy, md_cnt};
      if ($isunknown(a)) begin
        n_checks++;
        $display("FAIL unknown: got %b expected %b", a, e);
      end else begin
        check("stall_d", int'(a[EW-1]), int'(e[EW-1]));
        check("clr_e",   int'(a[EW-2]), int'(e[EW-2]));
        check("flush",   int'(a[EW-3]), int'(e[EW-3]));
        check("pc_sel",  int'(a[EW-4:EW-5]), int'(e[EW-4:EW-5]));
        check("exl",     int'(a[CNT_W+1]), int'(e[CNT_W+1]));
        check("md_busy", int'(a[CNT_W]), int'(e[CNT_W]));
        check("md_cnt",  int'(a[CNT_W-1:0]), int'(e[CNT_W-1:0]));
      end
    end
  end

  // driver: called at posedge+1; applies inputs, predicts, advances one edge
  task automatic step(input bit rst, input bit dh, input bit du, input bit st,
                      input bit dv, input bit exc, input bit irq, input bit ien,
                      input bit er, input bit do_chk = 1'b1);
    bit take, ret, flsh, busy, stall;
    int cnt, pcs;
    reset = rst; data_hazard = dh; d_uses_md = du; e_md_start = st;
    e_md_div = dv; exc_req = exc; int_req = irq; int_en = ien; eret_m = er;

    cnt   = (m_busy_to > m_cycle) ? (m_busy_to - m_cycle) : 0;
    take  = (exc || (irq && ien)) && !m_exl;
    ret   = er && !take;
    flsh  = take || ret;
    pcs   = take ? 1 : (ret ? 2 : 0);
    busy  = (cnt != 0) || (st && !flsh);
    stall = (dh || (du && busy)) && !flsh;
    if (do_chk)
      exp_q.push_back({stall, stall, flsh, 2'(pcs), m_exl, busy, CNT_W'(cnt)});

    @(posedge clk);
    if (rst) begin
      m_exl     = 1'b0;
      m_busy_to = 0;
    end else begin
      if (take)     m_exl = 1'b1;
      else if (ret) m_exl = 1'b0;
      if (st && !flsh && cnt == 0)
        m_busy_to = m_cycle + 1 + (dv ? DIV_LAT : MULT_LAT);
    end
    m_cycle++;
    #1;
  endtask

  task automatic idle(input int n, input bit du = 1'b0);
    for (int i = 0; i < n; i++) step(0, 0, du, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int guard;
    reset = 1'b1; data_hazard = 0; d_uses_md = 0; e_md_start = 0; e_md_div = 0;
    exc_req = 0; int_req = 0; int_en = 0; eret_m = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    idle(2);

    // mult stall with a dependent D instruction held
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    idle(7, 1'b1);

    // reset mid-countdown (md_cnt = 3 when reset rises)
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // div latency, second start at md_cnt=4 ignored
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(6);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(5);

    // flush beats stall, then requests ignored while exl
    step(0, 1, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // interrupt gating and eret
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // flush squashes same-cycle start; an earlier start survives a flush
    step(0, 0, 1, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 0, 0);
    idle(3, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0);
    idle(2);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
